// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle RV32I-subset controller: opcodes, FSM
// state encodings, datapath mux selects and ALU operation codes.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Encodings 11..15 are deliberately left unused; the FSM recovers to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_ctrl_alu_deco.sv
// ALU decoder shared with the single-cycle core: maps aluOp plus the
// instruction's funct fields onto the ALU operation select.
module aluDeco
  import multicycle_ctrl_pkg::*;
(
  input  logic       op5_i,
  input  logic       funct7b5_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] aluOp_i,
  output logic [2:0] aluControl_o
);

  // Only R-type (op5 set) with funct7[5] set turns funct3 000 into a subtract.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALU_ADD;
      ALUOP_SUB: aluControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  aluControl_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl_o = ALU_SLT;
          3'b110:  aluControl_o = ALU_OR;
          3'b111:  aluControl_o = ALU_AND;
          default: aluControl_o = ALU_ADD;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I-subset datapath: sequences each
// instruction over several cycles and drives every mux select and strobe.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         f3,
  input  logic               f7,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               adrSrc,
  output logic               memWrite,
  output logic               irWrite,
  output logic [1:0]         resSrc,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [2:0]         ALUcontrol,
  output logic [1:0]         immSrc,
  output logic               regWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] dbgState
);

  state_t     state_q, state_d;
  logic       pcUpdate, branch;
  logic       adrSrcRaw, memWriteRaw, irWriteRaw, regWriteRaw, illegalRaw;
  logic [1:0] resSrcRaw, aluSrcARaw, aluSrcBRaw, aluOp, immSrcRaw;
  logic [2:0] aluCtlRaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    adrSrcRaw   = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    resSrcRaw   = RES_ALUOUT;
    aluSrcARaw  = SRCA_PC;
    aluSrcBRaw  = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        aluSrcBRaw = SRCB_FOUR;
        resSrcRaw  = RES_ALURESULT;
        if (memReady) begin
          irWriteRaw = 1'b1;
          pcUpdate   = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        aluSrcARaw = SRCA_OLDPC;
        aluSrcBRaw = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegalRaw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcARaw = SRCA_RS1;
        aluSrcBRaw = SRCB_IMM;
        state_d    = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrcRaw = 1'b1;
        state_d   = memReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resSrcRaw   = RES_DATA;
        regWriteRaw = 1'b1;
      end
      // The write strobe stays up until memory accepts it.
      S_MEMWRITE: begin
        adrSrcRaw   = 1'b1;
        memWriteRaw = 1'b1;
        state_d     = memReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        aluSrcARaw = SRCA_RS1;
        aluSrcBRaw = SRCB_RS2;
        aluOp      = ALUOP_FUNCT;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcARaw = SRCA_RS1;
        aluSrcBRaw = SRCB_IMM;
        aluOp      = ALUOP_FUNCT;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regWriteRaw = 1'b1;
      end
      S_BRANCH: begin
        aluSrcARaw = SRCA_RS1;
        aluSrcBRaw = SRCB_RS2;
        aluOp      = ALUOP_SUB;
        branch     = 1'b1;
      end
      S_JAL: begin
        aluSrcARaw = SRCA_OLDPC;
        aluSrcBRaw = SRCB_FOUR;
        pcUpdate   = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: immSrcRaw = IMM_I;
      OP_SW:       immSrcRaw = IMM_S;
      OP_BR:       immSrcRaw = IMM_B;
      OP_JAL:      immSrcRaw = IMM_J;
      default:     immSrcRaw = IMM_I;
    endcase
  end

  aluDeco uAluDeco (
    .op5_i        (op[5]),
    .funct7b5_i   (f7),
    .funct3_i     (f3),
    .aluOp_i      (aluOp),
    .aluControl_o (aluCtlRaw)
  );

  // Reset gates every output combinationally so strobes drop the same instant.
  always_comb begin
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    resSrc     = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RS2;
    ALUcontrol = ALU_ADD;
    immSrc     = IMM_I;
    regWrite   = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      pcWrite    = pcUpdate | (branch & (zero ^ f3[0]));
      adrSrc     = adrSrcRaw;
      memWrite   = memWriteRaw;
      irWrite    = irWriteRaw;
      resSrc     = resSrcRaw;
      aluSrcA    = aluSrcARaw;
      aluSrcB    = aluSrcBRaw;
      ALUcontrol = aluCtlRaw;
      immSrc     = immSrcRaw;
      regWrite   = regWriteRaw;
      illegal    = illegalRaw;
    end
  end

  assign dbgState = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-written state sequences per
// instruction, with outputs predicted from a table of per-state behaviour.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, memReady;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] ALUcontrol;
  logic [3:0] dbgState;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtl;
    logic [1:0] immSrc;
    logic       regWrite;
    logic       illegal;
  } outs_t;

  int    passCount = 0;
  int    checkCount = 0;
  int    expStates[$];
  logic  readyVec[$];
  outs_t seen[16];
  int    memWriteCycles, regWriteCycles, illegalCycles;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .irWrite(irWrite), .resSrc(resSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ALUcontrol(ALUcontrol),
    .immSrc(immSrc), .regWrite(regWrite), .illegal(illegal),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  // Instruction-level meaning of each step, written from the mnemonic rather
  // than from any aluOp encoding.
  function automatic logic [2:0] expAluExec(input bit isR);
    case (f3)
      3'b000:  return (isR && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t model(input int s);
    outs_t o = '0;
    if (!rst_n) return o;
    if (op == 7'b0100011)      o.immSrc = 2'b01;
    else if (op == 7'b1100011) o.immSrc = 2'b10;
    else if (op == 7'b1101111) o.immSrc = 2'b11;
    case (s)
      0: begin
        o.aluSrcB = 2'b10; o.resSrc = 2'b10;
        o.irWrite = memReady; o.pcWrite = memReady;
      end
      1: begin
        o.aluSrcA = 2'b01; o.aluSrcB = 2'b01;
        o.illegal = !(op inside {7'b0000011, 7'b0100011, 7'b0110011,
                                 7'b0010011, 7'b1100011, 7'b1101111});
      end
      2: begin o.aluSrcA = 2'b10; o.aluSrcB = 2'b01; end
      3: o.adrSrc = 1'b1;
      4: begin o.resSrc = 2'b01; o.regWrite = 1'b1; end
      5: begin o.adrSrc = 1'b1; o.memWrite = 1'b1; end
      6: begin o.aluSrcA = 2'b10; o.aluCtl = expAluExec(1'b1); end
      7: begin o.aluSrcA = 2'b10; o.aluSrcB = 2'b01; o.aluCtl = expAluExec(1'b0); end
      8: o.regWrite = 1'b1;
      9: begin
        o.aluSrcA = 2'b10; o.aluCtl = 3'b001;
        o.pcWrite = f3[0] ? !zero : zero;
      end
      10: begin o.aluSrcA = 2'b01; o.aluSrcB = 2'b10; o.pcWrite = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic checkOutput(input int s);
    outs_t act, exp;
    act = {pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
           ALUcontrol, immSrc, regWrite, illegal};
    exp = model(s);
    checkCount++;
    if (dbgState == s[3:0]) passCount++;
    else $display("[TB] FAIL state t=%0t got %0d expected %0d", $time, dbgState, s);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL outputs state=%0d t=%0t got %h expected %h", s, $time, act, exp);
    seen[s[3:0]] = act;
    if (memWrite) memWriteCycles++;
    if (regWrite) regWriteCycles++;
    if (illegal)  illegalCycles++;
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
  endtask

  // Walks the hand-written state list; entered and left at posedge+1.
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] fn3,
                               input logic fn7, input logic z);
    op = o; f3 = fn3; f7 = fn7; zero = z;
    memWriteCycles = 0; regWriteCycles = 0; illegalCycles = 0;
    for (int i = 0; i < expStates.size(); i++) begin
      memReady = readyVec[i];
      @(negedge clk);
      checkOutput(expStates[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; memReady = 1'b0;
    #1 rst_n = 1'b0;
    #2 checkOutput(0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add, then sub
    expStates = '{0, 1, 6, 8, 0}; readyVec = '{1, 1, 1, 1, 0};
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0);
    checkVal("add_aluctl", seen[6].aluCtl, 0);
    checkVal("add_regwrite", seen[8].regWrite, 1);
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
    checkVal("sub_aluctl", seen[6].aluCtl, 1);

    // ori through EXECI, with a fetch stall first
    expStates = '{0, 0, 1, 7, 8, 0}; readyVec = '{0, 1, 1, 1, 1, 0};
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0);
    checkVal("ori_aluctl", seen[7].aluCtl, 3);

    // lw with two memory stalls
    expStates = '{0, 1, 2, 3, 3, 3, 4, 0}; readyVec = '{1, 1, 1, 0, 0, 1, 1, 0};
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    checkVal("lw_adrsrc", seen[3].adrSrc, 1);
    checkVal("lw_wb_ressrc", seen[4].resSrc, 1);
    checkVal("lw_regwrite_cycles", regWriteCycles, 1);

    // sw with three memory stalls
    expStates = '{0, 1, 2, 5, 5, 5, 5, 0}; readyVec = '{1, 1, 1, 0, 0, 0, 1, 0};
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    checkVal("sw_memwrite_cycles", memWriteCycles, 4);
    checkVal("sw_immsrc", seen[5].immSrc, 1);

    // branches
    expStates = '{0, 1, 9, 0}; readyVec = '{1, 1, 1, 0};
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
    checkVal("beq_taken_pcwrite", seen[9].pcWrite, 1);
    checkVal("beq_immsrc", seen[1].immSrc, 2);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
    checkVal("beq_nottaken_pcwrite", seen[9].pcWrite, 0);
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0);
    checkVal("bne_taken_pcwrite", seen[9].pcWrite, 1);
    checkVal("bne_immsrc", seen[1].immSrc, 2);

    // jal
    expStates = '{0, 1, 10, 8, 0}; readyVec = '{1, 1, 1, 1, 0};
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
    checkVal("jal_pcwrite", seen[10].pcWrite, 1);
    checkVal("jal_immsrc", seen[10].immSrc, 3);

    // unsupported opcode (lui)
    expStates = '{0, 1, 0}; readyVec = '{1, 1, 0};
    applyStimulus(7'b0110111, 3'b000, 1'b0, 1'b0);
    checkVal("illegal_pulse", seen[1].illegal, 1);
    checkVal("illegal_cycles", illegalCycles, 1);
    checkVal("illegal_no_write", regWriteCycles + memWriteCycles, 0);

    // reset asserted while a store is waiting in MEMWRITE
    expStates = '{0, 1, 2, 5}; readyVec = '{1, 1, 1, 0};
    applyStimulus(7'b0100011, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput(0);
    checkVal("reset_memwrite", memWrite, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    checkOutput(0);
    checkVal("post_reset_irwrite", irWrite, 1);
    @(posedge clk); #1;
    expStates = '{1, 2, 5, 0}; readyVec = '{1, 1, 1, 0};
    applyStimulus(7'b0100011, 3'b000, 1'b0, 1'b0);
    checkVal("post_reset_sw_memwrite", memWriteCycles, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
